// File: rtl/pre_fetch_stage_wide.sv
// Pre-fetch stage: picks the next fetch-block address (sequential, branch target, correction, flush) and issues ICache requests.
// Latency: block handed to fetch combinationally in the cycle the ICache accepts it (or a misaligned PC is forwarded).
// Backpressure: holds next_pc/icache_addr stable while fs_allowin or icache_addr_ok is low; flush suppresses the handoff.
module pre_fetch_stage_wide #(
   parameter int          FETCH_WIDTH = 2,
   parameter logic [31:0] RESET_PC    = 32'hbfc0_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [31:0]            flush_pc,
   input  logic                   fs_allowin,
   output logic                   pfs_to_valid,
   input  logic                   bp_valid,
   input  logic                   bp_taken,
   input  logic [31:0]            bp_target,
   input  logic                   bp_delay_fetched,
   input  logic                   corr_valid,
   input  logic [31:0]            corr_target,
   output logic                   icache_req,
   output logic [31:0]            icache_addr,
   input  logic                   icache_addr_ok,
   output logic [31:0]            inst_vaddr,
   output logic [31:0]            out_pc,
   output logic [FETCH_WIDTH-1:0] out_slot_valid,
   output logic                   out_adel,
   output logic [31:0]            out_badvaddr
);

   localparam int          BLK       = 4 * FETCH_WIDTH;
   localparam int          OFF       = $clog2(BLK);
   localparam logic [31:0] BLK_BYTES = 32'(BLK);
   localparam logic [31:0] BLK_MASK  = ~(BLK_BYTES - 32'd1);

   // SEQ: sequential fetch; DELAY: fetching the delay slot before jumping;
   // TARGET: next block is the predicted target; CORR: next block is the BPU correction.
   typedef enum logic [1:0] {
      ST_SEQ    = 2'd0,
      ST_DELAY  = 2'd1,
      ST_TARGET = 2'd2,
      ST_CORR   = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        pfs_valid;
   logic [31:0] seq_pc, seq_pc_nxt;
   logic [31:0] br_tgt, br_tgt_nxt;
   logic [31:0] corr_tgt, corr_tgt_nxt;
   logic [31:0] next_pc;
   logic [31:0] blk_addr;
   logic        misalign;
   logic        adv;

   // Select the PC of the block to fetch next from the current state.
   always_comb begin
      next_pc = seq_pc;
      case (state)
         ST_TARGET: next_pc = br_tgt;
         ST_CORR:   next_pc = corr_tgt;
         default:   next_pc = seq_pc;
      endcase
   end

   assign blk_addr = next_pc & BLK_MASK;
   assign misalign = pfs_valid && (next_pc[1:0] != 2'b00);

   // A misaligned PC never goes to the ICache; it is forwarded directly as an AdEL block.
   assign icache_req = pfs_valid && fs_allowin && !flush && !misalign;
   assign adv        = (icache_req && icache_addr_ok) || (misalign && fs_allowin && !flush);

   // pfs_valid is cleared asynchronously, so gating with it forces zeros during reset.
   assign icache_addr  = pfs_valid ? blk_addr : 32'd0;
   assign inst_vaddr   = icache_addr;
   assign pfs_to_valid = adv;
   assign out_pc       = adv ? blk_addr : 32'd0;
   assign out_adel     = adv && misalign;
   assign out_badvaddr = adv ? next_pc : 32'd0;

   // Slots below the entry offset of a redirected PC are not part of the fetched stream.
   generate
      if (FETCH_WIDTH == 1) begin : g_single
         assign out_slot_valid = adv;
      end else begin : g_multi
         logic [OFF-3:0] first_slot;
         assign first_slot = next_pc[OFF-1:2];
         always_comb begin
            out_slot_valid = '0;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
               out_slot_valid[i] = adv && (i >= int'(first_slot));
            end
         end
      end
   endgenerate

   // Next state and redirect registers: flush beats correction beats prediction.
   always_comb begin
      state_nxt    = state;
      seq_pc_nxt   = seq_pc;
      br_tgt_nxt   = br_tgt;
      corr_tgt_nxt = corr_tgt;
      if (flush) begin
         seq_pc_nxt = flush_pc;
         state_nxt  = ST_SEQ;
      end else begin
         if (adv) begin
            seq_pc_nxt = blk_addr + BLK_BYTES;
         end
         if (corr_valid) begin
            corr_tgt_nxt = corr_target;
            state_nxt    = ST_CORR;
         end else if (bp_valid && bp_taken && (state == ST_SEQ)) begin
            // Jump straight to the target only if the delay slot is already fetched.
            br_tgt_nxt = bp_target;
            state_nxt  = bp_delay_fetched ? ST_TARGET : ST_DELAY;
         end else if (adv) begin
            case (state)
               ST_DELAY:  state_nxt = ST_TARGET;
               ST_TARGET: state_nxt = ST_SEQ;
               ST_CORR:   state_nxt = ST_SEQ;
               default:   state_nxt = ST_SEQ;
            endcase
         end
      end
   end

   // State and PC registers; pfs_valid rises on the first edge after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pfs_valid <= 1'b0;
         state     <= ST_SEQ;
         seq_pc    <= RESET_PC;
         br_tgt    <= 32'd0;
         corr_tgt  <= 32'd0;
      end else begin
         pfs_valid <= 1'b1;
         state     <= state_nxt;
         seq_pc    <= seq_pc_nxt;
         br_tgt    <= br_tgt_nxt;
         corr_tgt  <= corr_tgt_nxt;
      end
   end

endmodule

// File: tb/tb_pre_fetch_stage_wide.sv
// Bench for pre_fetch_stage_wide with FETCH_WIDTH=4: expected handed-off blocks are queued
// as stimulus is driven and popped by a monitor on every pfs_to_valid; scenario tasks add inline checks.
module tb_pre_fetch_stage_wide;

   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [31:0]   flush_pc = 32'd0;
   logic          fs_allowin = 1'b0;
   logic          pfs_to_valid;
   logic          bp_valid = 1'b0;
   logic          bp_taken = 1'b0;
   logic [31:0]   bp_target = 32'd0;
   logic          bp_delay_fetched = 1'b0;
   logic          corr_valid = 1'b0;
   logic [31:0]   corr_target = 32'd0;
   logic          icache_req;
   logic [31:0]   icache_addr;
   logic          icache_addr_ok = 1'b1;
   logic [31:0]   inst_vaddr;
   logic [31:0]   out_pc;
   logic [FW-1:0] out_slot_valid;
   logic          out_adel;
   logic [31:0]   out_badvaddr;

   typedef struct packed {
      logic [31:0]   pc;
      logic [FW-1:0] mask;
      logic          adel;
      logic [31:0]   bad;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   pre_fetch_stage_wide #(.FETCH_WIDTH(FW), .RESET_PC(32'hbfc0_0000)) dut (
      .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
      .fs_allowin(fs_allowin), .pfs_to_valid(pfs_to_valid),
      .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_target(bp_target),
      .bp_delay_fetched(bp_delay_fetched), .corr_valid(corr_valid), .corr_target(corr_target),
      .icache_req(icache_req), .icache_addr(icache_addr), .icache_addr_ok(icache_addr_ok),
      .inst_vaddr(inst_vaddr), .out_pc(out_pc), .out_slot_valid(out_slot_valid),
      .out_adel(out_adel), .out_badvaddr(out_badvaddr)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every handed-off block must match the oldest expected one.
   always @(negedge clk) begin
      if (pfs_to_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_block got pc=%h mask=%b adel=%b bad=%h, required none",
                     out_pc, out_slot_valid, out_adel, out_badvaddr);
         end else begin
            e = exp_q.pop_front();
            if ({out_pc, out_slot_valid, out_adel, out_badvaddr} !== {e.pc, e.mask, e.adel, e.bad}) begin
               bad++;
               $display("FAIL block got pc=%h mask=%b adel=%b bad=%h, required pc=%h mask=%b adel=%b bad=%h",
                        out_pc, out_slot_valid, out_adel, out_badvaddr, e.pc, e.mask, e.adel, e.bad);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [FW-1:0] mask,
                       input logic adel, input logic [31:0] badv);
      exp_t x;
      x.pc = pc; x.mask = mask; x.adel = adel; x.bad = badv;
      exp_q.push_back(x);
   endtask

   task automatic restart();
      reset = 1'b1; fs_allowin = 1'b0; flush = 1'b0; corr_valid = 1'b0;
      bp_valid = 1'b0; bp_taken = 1'b0; icache_addr_ok = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_reset_and_seq();
      fs_allowin = 1'b1;
      cycle();
      total++;
      if ({icache_req, icache_addr, pfs_to_valid, out_slot_valid, out_pc, out_adel} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got req=%b addr=%h vld=%b mask=%b pc=%h adel=%b, required all 0",
                  icache_req, icache_addr, pfs_to_valid, out_slot_valid, out_pc, out_adel);
      end
      reset = 1'b0;
      cycle();
      push(32'hbfc00000, 4'b1111, 1'b0, 32'hbfc00000);
      push(32'hbfc00010, 4'b1111, 1'b0, 32'hbfc00010);
      push(32'hbfc00020, 4'b1111, 1'b0, 32'hbfc00020);
      #1;
      total++;
      if (icache_addr !== 32'hbfc00000 || inst_vaddr !== 32'hbfc00000 || icache_req !== 1'b1) begin
         bad++;
         $display("FAIL first_req got req=%b addr=%h vaddr=%h, required 1 bfc00000 bfc00000",
                  icache_req, icache_addr, inst_vaddr);
      end
      cycle(); cycle(); cycle();
      fs_allowin = 1'b0;
      #1;
      total++;
      if (icache_addr !== 32'hbfc00030 || icache_req !== 1'b0) begin
         bad++;
         $display("FAIL seq_hold got req=%b addr=%h, required 0 bfc00030", icache_req, icache_addr);
      end
   endtask

   task automatic test_branch(input logic df);
      restart();
      fs_allowin = 1'b1;
      push(32'hbfc00000, 4'b1111, 1'b0, 32'hbfc00000);
      cycle();
      bp_valid = 1'b1; bp_taken = 1'b1; bp_target = 32'hbfc00104; bp_delay_fetched = df;
      push(32'hbfc00010, 4'b1111, 1'b0, 32'hbfc00010);
      cycle();
      bp_valid = 1'b0; bp_taken = 1'b0;
      if (!df) begin
         push(32'hbfc00020, 4'b1111, 1'b0, 32'hbfc00020);
         cycle();
      end
      #1;
      total++;
      if (icache_addr !== 32'hbfc00100) begin
         bad++;
         $display("FAIL branch_target df=%b got addr=%h, required bfc00100", df, icache_addr);
      end
      push(32'hbfc00100, 4'b1110, 1'b0, 32'hbfc00104);
      cycle();
      push(32'hbfc00110, 4'b1111, 1'b0, 32'hbfc00110);
      cycle();
      fs_allowin = 1'b0;
      #1;
      total++;
      if (icache_addr !== 32'hbfc00120) begin
         bad++;
         $display("FAIL branch_after df=%b got addr=%h, required bfc00120", df, icache_addr);
      end
   endtask

   task automatic test_stall();
      restart();
      fs_allowin = 1'b1;
      push(32'hbfc00000, 4'b1111, 1'b0, 32'hbfc00000);
      cycle();
      bp_valid = 1'b1; bp_taken = 1'b1; bp_target = 32'hbfc00104; bp_delay_fetched = 1'b1;
      push(32'hbfc00010, 4'b1111, 1'b0, 32'hbfc00010);
      cycle();
      bp_valid = 1'b0; bp_taken = 1'b0;
      icache_addr_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (icache_addr !== 32'hbfc00100 || icache_req !== 1'b1 || pfs_to_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got addr=%h req=%b vld=%b, required bfc00100 1 0",
                     k, icache_addr, icache_req, pfs_to_valid);
         end
         cycle();
      end
      icache_addr_ok = 1'b1;
      push(32'hbfc00100, 4'b1110, 1'b0, 32'hbfc00104);
      cycle();
      fs_allowin = 1'b0;
      #1;
      total++;
      if (icache_addr !== 32'hbfc00110) begin
         bad++;
         $display("FAIL stall_after got addr=%h, required bfc00110", icache_addr);
      end
   endtask

   task automatic test_flush_corr();
      restart();
      fs_allowin = 1'b1;
      flush = 1'b1; flush_pc = 32'hbfc00380;
      corr_valid = 1'b1; corr_target = 32'h12345670;
      #1;
      total++;
      if (icache_req !== 1'b0 || pfs_to_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_block got req=%b vld=%b, required 0 0", icache_req, pfs_to_valid);
      end
      cycle();
      flush = 1'b0; corr_valid = 1'b0;
      push(32'hbfc00380, 4'b1111, 1'b0, 32'hbfc00380);
      cycle();
      fs_allowin = 1'b0;
      #1;
      total++;
      if (icache_addr !== 32'hbfc00390) begin
         bad++;
         $display("FAIL flush_after got addr=%h, required bfc00390", icache_addr);
      end
   endtask

   task automatic test_wrap();
      restart();
      fs_allowin = 1'b1;
      flush = 1'b1; flush_pc = 32'hfffffff8;
      cycle();
      flush = 1'b0;
      push(32'hfffffff0, 4'b1100, 1'b0, 32'hfffffff8);
      cycle();
      push(32'h00000000, 4'b1111, 1'b0, 32'h00000000);
      cycle();
      fs_allowin = 1'b0;
      #1;
      total++;
      if (icache_addr !== 32'h00000010) begin
         bad++;
         $display("FAIL wrap got addr=%h, required 00000010", icache_addr);
      end
   endtask

   task automatic test_misalign_and_reset();
      restart();
      corr_valid = 1'b1; corr_target = 32'h80000002;
      cycle();
      corr_valid = 1'b0; fs_allowin = 1'b1;
      push(32'h80000000, 4'b1111, 1'b1, 32'h80000002);
      #1;
      total++;
      if (icache_req !== 1'b0 || pfs_to_valid !== 1'b1 || out_adel !== 1'b1) begin
         bad++;
         $display("FAIL adel got req=%b vld=%b adel=%b, required 0 1 1", icache_req, pfs_to_valid, out_adel);
      end
      cycle();
      push(32'h80000010, 4'b1111, 1'b0, 32'h80000010);
      #1;
      total++;
      if (icache_req !== 1'b1 || icache_addr !== 32'h80000010) begin
         bad++;
         $display("FAIL adel_after got req=%b addr=%h, required 1 80000010", icache_req, icache_addr);
      end
      cycle();
      icache_addr_ok = 1'b0;
      cycle(); cycle();
      reset = 1'b1;
      #1;
      total++;
      if ({icache_req, icache_addr, inst_vaddr, pfs_to_valid, out_slot_valid, out_pc, out_badvaddr} !== '0) begin
         bad++;
         $display("FAIL midreset got req=%b addr=%h vld=%b mask=%b pc=%h, required all 0",
                  icache_req, icache_addr, pfs_to_valid, out_slot_valid, out_pc);
      end
      cycle();
      reset = 1'b0; icache_addr_ok = 1'b1;
      cycle();
      push(32'hbfc00000, 4'b1111, 1'b0, 32'hbfc00000);
      #1;
      total++;
      if (icache_addr !== 32'hbfc00000) begin
         bad++;
         $display("FAIL restart got addr=%h, required bfc00000", icache_addr);
      end
      cycle();
      fs_allowin = 1'b0;
      cycle();
   endtask

   initial begin
      test_reset_and_seq();
      test_branch(1'b0);
      test_branch(1'b1);
      test_stall();
      test_flush_corr();
      test_wrap();
      test_misalign_and_reset();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover got %0d pending blocks, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pre_fetch_stage_wide.md
Name: pre_fetch_stage_wide

Overview:
Parametrised successor of the pre-fetch stage. Generates next fetch-block address for an N-instruction-wide front end and issues ICache requests. Selects next block from sequential PC, predicted branch target (MIPS delay-slot aware), BPU correction or flush redirect. Sits between BPU/flush control and the fetch stage, and produces per-slot valid mask plus AdEL exception info per block.

Parameters:
FETCH_WIDTH, 2, instructions per fetch block; power of two, 1..8; block size BLK = 4*FETCH_WIDTH bytes, OFF = log2(BLK).
RESET_PC, 32'hbfc0_0000, first fetch address after reset.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; redirect to flush_pc
flush_pc  in  32  flush redirect PC (exception vector / EPC)
fs_allowin  in  1  fetch stage can accept a block
pfs_to_valid  out  1  block handed to fetch stage this cycle
bp_valid  in  1  BPU prediction valid
bp_taken  in  1  predicted taken
bp_target  in  32  predicted target
bp_delay_fetched  in  1  delay slot of the predicted branch is already in an accepted block
corr_valid  in  1  BPU misprediction correction
corr_target  in  32  corrected PC
icache_req  out  1  ICache request
icache_addr  out  32  block-aligned request address
icache_addr_ok  in  1  ICache accepted request
inst_vaddr  out  32  equals icache_addr (to MMU)
out_pc  out  32  base PC of handed-off block (low OFF bits zero)
out_slot_valid  out  FETCH_WIDTH  per-instruction slot valid
out_adel  out  1  block carries AdEL exception
out_badvaddr  out  32  faulting address (next_pc unmodified)

Behaviour:
- Reset (async): pfs_valid=0, seq_pc=RESET_PC, state=SEQ, br_tgt=0, corr_tgt=0. All outputs 0 while reset high. pfs_valid becomes 1 on first clock edge after reset release.
- States: SEQ, DELAY, TARGET, CORR. next_pc mux: SEQ/DELAY -> seq_pc; TARGET -> br_tgt; CORR -> corr_tgt.
- misalign = pfs_valid && next_pc[1:0]!=0.
- icache_req = pfs_valid && fs_allowin && !flush && !misalign. icache_addr = next_pc with low OFF bits cleared.
- adv = (icache_req && icache_addr_ok) || (misalign && fs_allowin && !flush). pfs_to_valid = adv.
- On adv: seq_pc <= icache_addr + BLK (wraps mod 2^32). out_slot_valid[i] = pfs_to_valid && (i >= next_pc[OFF-1:2]). out_pc = icache_addr. out_adel = misalign. out_badvaddr = next_pc. All of these are combinational in the adv cycle.
- Without adv, next_pc and icache_addr hold stable (including while icache_addr_ok=0 for many cycles).
- Priority per edge: flush > corr_valid > bp.
  - flush: seq_pc <= flush_pc, state <= SEQ; pending bp/corr dropped.
  - corr_valid: corr_tgt <= corr_target, state <= CORR (from any state).
  - bp_valid&&bp_taken in SEQ: br_tgt <= bp_target; state <= bp_delay_fetched ? TARGET : DELAY. Ignored in DELAY/TARGET/CORR.
- Transitions on adv (no higher-priority event): DELAY->TARGET; TARGET->SEQ; CORR->SEQ (misaligned advance included); SEQ->SEQ.
- A bp arriving in the same cycle as an adv in SEQ: seq_pc still updates; the state takes the bp transition.
- FETCH_WIDTH=1: OFF=2, slot mask always 1'b1.

Test Plan:
- FETCH_WIDTH=4, release reset, addr_ok=1, fs_allowin=1 -> icache_addr 0xbfc00000, then 0xbfc00010, 0xbfc00020; out_slot_valid=4'b1111 each.
- Block 0xbfc00010 accepted; bp taken, target 0xbfc00104, bp_delay_fetched=0 -> next requests 0xbfc00020 (DELAY), then 0xbfc00100 with mask 4'b1110, then 0xbfc00110.
- Same branch with bp_delay_fetched=1 -> next request 0xbfc00100 directly.
- addr_ok=0 for 3 cycles during TARGET -> icache_addr held at 0xbfc00100, pfs_to_valid=0; accepted on 4th cycle.
- flush (flush_pc=0xbfc00380) with corr_valid same cycle -> next request 0xbfc00380, state SEQ; corr_target ignored.
- corr_target 0x80000002 -> icache_req=0, pfs_to_valid=1, out_adel=1, out_badvaddr=0x80000002, out_pc=0x80000000; then seq 0x80000010. Assert reset mid-stall -> outputs 0 immediately, restart at 0xbfc00000.
